timer_prescaler: RTL



---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_sync_edge.sv | 31 +++
 rtl/timer_prescaler.sv | 85 ++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared constants and helpers for the timer prescaler family.
// The optional external-clock source is enabled with TIMER_PRESC_EXTCLK_EN.
package timer_pkg;

    localparam int CKS_W_DEFAULT = 2;
    localparam int CNT_W_DEFAULT = 2 ** CKS_W_DEFAULT;

    // Terminal count for a ratio select: 2^(sel+1)-1, returned at full int width.
    function automatic logic [31:0] ratio_mask(input int sel);
        ratio_mask = (32'd1 << (sel + 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/timer_sync_edge.sv
// Two-flop synchroniser with a rising-edge pulse for the external timer clock.
// Only compiled when TIMER_PRESC_EXTCLK_EN is defined.
`ifdef TIMER_PRESC_EXTCLK_EN
module timer_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    // Pulse is decoded from registers only, so it is glitch-free for the counter.
    assign rise = sync & ~prev;

endmodule
`endif

// File: rtl/timer_prescaler.sv
// Modulo-2^(cks+1) prescaler producing a count-enable tick and a 50% divided level.
// Define TIMER_PRESC_EXTCLK_EN to add the ext_clk/src external count source.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int CKS_W = CKS_W_DEFAULT
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             en,
    input  logic             clr,
    input  logic [CKS_W-1:0] cks,
`ifdef TIMER_PRESC_EXTCLK_EN
    input  logic             ext_clk,
    input  logic             src,
`endif
    output logic             clk_tick,
    output logic             clk_div,
    output logic [CKS_W-1:0] sel_active
);

    localparam int CNT_W = 2 ** CKS_W;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [31:0]      mask_full;
    logic             step;
    logic             wrap;
    logic             load_sel;

`ifdef TIMER_PRESC_EXTCLK_EN
    logic src_active;
    logic ext_rise;

    timer_sync_edge u_sync_edge (
        .clk  (pclk),
        .rst  (preset),
        .din  (ext_clk),
        .rise (ext_rise)
    );

    assign step = en && (!src_active || ext_rise);

    // Source select follows the same boundary rule as the ratio select.
    always_ff @(posedge pclk) begin
        if (preset) begin
            src_active <= 1'b0;
        end else if (clr || load_sel) begin
            src_active <= src;
        end
    end
`else
    assign step = en;
`endif

    assign mask_full = ratio_mask(int'(sel_active));
    assign wrap      = step && ({{(32-CNT_W){1'b0}}, cnt} == mask_full);
    assign cnt_next  = wrap ? '0 : cnt + CNT_W'(1);
    // A pending select is taken at a period boundary, or immediately while stopped.
    assign load_sel  = wrap || !en;

    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt        <= '0;
            clk_tick   <= 1'b0;
            clk_div    <= 1'b0;
            sel_active <= '0;
        end else if (clr) begin
            cnt        <= '0;
            clk_tick   <= 1'b0;
            clk_div    <= 1'b0;
            sel_active <= cks;
        end else begin
            clk_tick <= wrap;
            if (step) begin
                cnt     <= cnt_next;
                clk_div <= cnt_next[sel_active];
            end
            if (load_sel) begin
                sel_active <= cks;
            end
        end
    end

endmodule
